// File: rtl/mcp4725_pkg.sv
// Shared encodings and defaults for the MCP4725-style I2C fast-write target,
// kept here so an initiator model can reuse the same constants.
package mcp4725_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_HI_BYTE  = 3'd3,
    ST_HI_ACK   = 3'd4,
    ST_LO_BYTE  = 3'd5,
    ST_LO_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } state_t;

  localparam logic [1:0] CMD_FAST_WRITE   = 2'b00;
  localparam logic [6:0] MCP4725_DEV_ADDR = 7'b1100001;
  localparam int         BITS_PER_BYTE    = 8;

  // Address byte selects this target only for a write (R/W bit low).
  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev);
    return (addr_byte[7:1] == dev) && !addr_byte[0];
  endfunction

endpackage

// File: rtl/mcp4725_i2c_target_if.sv
// Synchronized I2C line events passed from the line conditioner to the
// protocol FSM.
interface mcp4725_i2c_target_if;
  logic sda;
  logic scl_rise;
  logic scl_fall;
  logic start;
  logic stop;

  modport master (output sda, scl_rise, scl_fall, start, stop);
  modport slave  (input  sda, scl_rise, scl_fall, start, stop);
endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into clk and derives SCL edges plus START/STOP
// conditions from the synchronized copies.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl_pin,
  input  logic                  sda_pin,
  mcp4725_i2c_target_if.master  ev
);

  logic [SYNC_STAGES-1:0] scl_sync_reg;
  logic [SYNC_STAGES-1:0] sda_sync_reg;
  logic [SYNC_STAGES-1:0] scl_sync_next;
  logic [SYNC_STAGES-1:0] sda_sync_next;
  logic                   scl_prev_reg;
  logic                   sda_prev_reg;
  logic                   scl_s;
  logic                   sda_s;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign scl_sync_next[gi] = scl_pin;
        assign sda_sync_next[gi] = sda_pin;
      end else begin : g_rest
        assign scl_sync_next[gi] = scl_sync_reg[gi-1];
        assign sda_sync_next[gi] = sda_sync_reg[gi-1];
      end
    end
  endgenerate

  // Preset to 1 so a released reset over an idle bus raises no false events.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
    end else begin
      scl_sync_reg <= scl_sync_next;
      sda_sync_reg <= sda_sync_next;
      scl_prev_reg <= scl_s;
      sda_prev_reg <= sda_s;
    end
  end

  assign scl_s = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s = sda_sync_reg[SYNC_STAGES-1];

  assign ev.sda      = sda_s;
  assign ev.scl_rise = scl_s & ~scl_prev_reg;
  assign ev.scl_fall = ~scl_s & scl_prev_reg;
  assign ev.start    = scl_s & scl_prev_reg & sda_prev_reg & ~sda_s;
  assign ev.stop     = scl_s & scl_prev_reg & ~sda_prev_reg & sda_s;

endmodule

// File: rtl/mcp4725_i2c_target.sv
// MCP4725-style I2C write target: accepts fast-write hi/lo byte pairs and
// commits a 12-bit DAC code plus power-down bits on each completed pair.
module mcp4725_i2c_target
  import mcp4725_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = MCP4725_DEV_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        reset,
  input  logic        i_scl,
  inout  wire         io_sda,
  output logic [11:0] o_dac_code,
  output logic [1:0]  o_pd,
  output logic        o_valid,
  output logic        o_busy
);

  mcp4725_i2c_target_if ev_bus ();

  i2c_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk     (i_clk),
    .reset   (reset),
    .scl_pin (i_scl),
    .sda_pin (io_sda),
    .ev      (ev_bus.master)
  );

  state_t      state_reg;
  logic [3:0]  bit_cnt_reg;
  logic [7:0]  shift_reg;
  logic [5:0]  hi_reg;
  logic        sda_low_reg;
  logic [11:0] dac_code_reg;
  logic [1:0]  pd_reg;
  logic        valid_reg;
  logic        busy_reg;
  logic        byte_state;
  logic        byte_done;

  assign byte_state = (state_reg == ST_ADDR) || (state_reg == ST_HI_BYTE) ||
                      (state_reg == ST_LO_BYTE);
  assign byte_done  = (bit_cnt_reg == 4'(BITS_PER_BYTE));

  always_ff @(posedge i_clk) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      bit_cnt_reg  <= 4'd0;
      shift_reg    <= 8'h00;
      hi_reg       <= 6'h00;
      sda_low_reg  <= 1'b0;
      dac_code_reg <= 12'h000;
      pd_reg       <= 2'b00;
      valid_reg    <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      valid_reg <= 1'b0;

      if (ev_bus.scl_rise && byte_state && !byte_done) begin
        shift_reg   <= {shift_reg[6:0], ev_bus.sda};
        bit_cnt_reg <= bit_cnt_reg + 4'd1;
      end

      if (ev_bus.start) begin
        state_reg   <= ST_ADDR;
        bit_cnt_reg <= 4'd0;
        sda_low_reg <= 1'b0;
        busy_reg    <= 1'b1;
      end else if (ev_bus.stop) begin
        state_reg   <= ST_IDLE;
        bit_cnt_reg <= 4'd0;
        sda_low_reg <= 1'b0;
        busy_reg    <= 1'b0;
      end else if (ev_bus.scl_fall) begin
        // The fall ending a byte's 8th clock opens the ACK slot; the fall
        // ending the 9th clock closes it.
        case (state_reg)
          ST_ADDR: begin
            if (byte_done) begin
              bit_cnt_reg <= 4'd0;
              if (addr_match(shift_reg, DEV_ADDR)) begin
                state_reg   <= ST_ADDR_ACK;
                sda_low_reg <= 1'b1;
              end else begin
                state_reg <= ST_IGNORE;
              end
            end
          end
          ST_ADDR_ACK: begin
            sda_low_reg <= 1'b0;
            state_reg   <= ST_HI_BYTE;
          end
          ST_HI_BYTE: begin
            if (byte_done) begin
              bit_cnt_reg <= 4'd0;
              if (shift_reg[7:6] == CMD_FAST_WRITE) begin
                hi_reg      <= shift_reg[5:0];
                state_reg   <= ST_HI_ACK;
                sda_low_reg <= 1'b1;
              end else begin
                state_reg <= ST_IGNORE;
              end
            end
          end
          ST_HI_ACK: begin
            sda_low_reg <= 1'b0;
            state_reg   <= ST_LO_BYTE;
          end
          ST_LO_BYTE: begin
            if (byte_done) begin
              bit_cnt_reg <= 4'd0;
              state_reg   <= ST_LO_ACK;
              sda_low_reg <= 1'b1;
            end
          end
          ST_LO_ACK: begin
            // shift_reg is frozen during the ACK clock, so it still holds D7..D0.
            sda_low_reg  <= 1'b0;
            dac_code_reg <= {hi_reg[3:0], shift_reg};
            pd_reg       <= hi_reg[5:4];
            valid_reg    <= 1'b1;
            state_reg    <= ST_HI_BYTE;
          end
          default: ;
        endcase
      end
    end
  end

  assign io_sda     = sda_low_reg ? 1'b0 : 1'bz;
  assign o_dac_code = dac_code_reg;
  assign o_pd       = pd_reg;
  assign o_valid    = valid_reg;
  assign o_busy     = busy_reg;

endmodule

// File: tb/tb_mcp4725_i2c_target.sv
// Directed bench for mcp4725_i2c_target: bit-banged I2C initiator, byte-level
// reference model and a per-cycle output checker.
module tb_mcp4725_i2c_target;
  import mcp4725_pkg::*;

  localparam int         Q   = 8;
  localparam logic [6:0] DEV = MCP4725_DEV_ADDR;

  typedef struct {
    logic [11:0] code;
    logic [1:0]  pd;
  } commit_t;

  logic        clk          = 1'b0;
  logic        reset        = 1'b0;
  logic        scl          = 1'b1;
  logic        host_sda_low = 1'b0;
  logic        rst_at_edge  = 1'b0;
  wire         sda_line;
  logic [11:0] dac_code;
  logic [1:0]  pd;
  logic        valid;
  logic        busy;

  commit_t     exp_q[$];
  commit_t     seen_q[$];
  logic [11:0] model_code  = 12'h000;
  logic [1:0]  model_pd    = 2'b00;
  int          total       = 0;
  int          bad         = 0;
  int          valid_cnt   = 0;
  int          dut_low_cnt = 0;

  mcp4725_i2c_target_if mark ();
  assign mark.sda  = sda_line;
  assign sda_line  = host_sda_low ? 1'b0 : 1'bz;
  pullup (sda_line);

  always #5 clk = ~clk;
  always @(posedge clk) rst_at_edge <= reset;

  mcp4725_i2c_target dut (
    .i_clk      (clk),
    .reset      (reset),
    .i_scl      (scl),
    .io_sda     (sda_line),
    .o_dac_code (dac_code),
    .o_pd       (pd),
    .o_valid    (valid),
    .o_busy     (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Committed outputs must equal the model value on every cycle.
  task automatic monitor();
    commit_t c;
    forever begin
      @(negedge clk);
      if (!rst_at_edge) begin
        model_code = 12'h000;
        model_pd   = 2'b00;
      end else begin
        if (valid === 1'b1) begin
          valid_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", 32'(valid), 32'd0);
          end else begin
            c          = exp_q.pop_front();
            model_code = c.code;
            model_pd   = c.pd;
            seen_q.push_back(c);
          end
        end
        if (!host_sda_low && sda_line === 1'b0) dut_low_cnt++;
      end
      chk("dac_code", 32'(dac_code), 32'(model_code));
      chk("pd", 32'(pd), 32'(model_pd));
    end
  endtask

  task automatic qwait();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    host_sda_low = 1'b0; qwait();
    scl = 1'b1;          qwait();
    host_sda_low = 1'b1; mark.start = 1'b1; qwait();
    mark.start = 1'b0;   scl = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    host_sda_low = 1'b1; qwait();
    scl = 1'b1;          qwait();
    host_sda_low = 1'b0; mark.stop = 1'b1; qwait();
    mark.stop = 1'b0;
  endtask

  task automatic write_bit(input logic b);
    host_sda_low = ~b; qwait();
    scl = 1'b1;        qwait(); qwait();
    scl = 1'b0;        qwait();
  endtask

  task automatic read_ack(output bit ack);
    host_sda_low = 1'b0; qwait();
    scl = 1'b1;          qwait();
    ack = (sda_line === 1'b0);
    qwait();
    scl = 1'b0;          qwait();
  endtask

  task automatic write_byte(input logic [7:0] b, output bit ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_ack(ack);
  endtask

  // Byte-level protocol rules: address, then fast-write hi/lo pairs.
  task automatic model_txn(input int n, input logic [47:0] bytes, output bit acks[6]);
    int          phase;
    logic [7:0]  b;
    logic [7:0]  hi;
    commit_t     c;
    phase = 0;
    hi    = 8'h00;
    for (int i = 0; i < 6; i++) acks[i] = 1'b0;
    for (int i = 0; i < n; i++) begin
      b = bytes[8*(n-1-i) +: 8];
      if (phase == 0) begin
        acks[i] = (b[7:1] == DEV) && (b[0] == 1'b0);
        phase   = acks[i] ? 1 : 3;
      end else if (phase == 1) begin
        acks[i] = (b[7:6] == 2'b00);
        hi      = b;
        phase   = acks[i] ? 2 : 3;
      end else if (phase == 2) begin
        acks[i] = 1'b1;
        c.code  = {hi[3:0], b};
        c.pd    = hi[5:4];
        exp_q.push_back(c);
        phase   = 1;
      end
    end
  endtask

  task automatic run_txn(input string name, input int n, input logic [47:0] bytes,
                         input bit do_stop, input int exp_commits);
    bit acks[6];
    bit ack;
    int v0;
    model_txn(n, bytes, acks);
    v0 = valid_cnt;
    seen_q.delete();
    i2c_start();
    chk({name, "_busy_start"}, 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      write_byte(bytes[8*(n-1-i) +: 8], ack);
      chk($sformatf("%s_ack%0d", name, i), 32'(ack), 32'(acks[i]));
    end
    if (do_stop) begin
      i2c_stop();
      qwait();
      chk({name, "_busy_stop"}, 32'(busy), 32'd0);
    end
    qwait();
    chk({name, "_pulses"}, 32'(valid_cnt - v0), 32'(exp_commits));
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    $display("txn %s: bytes=%0d commits=%0d code=%03h pd=%02b", name, n,
             valid_cnt - v0, dac_code, pd);
  endtask

  task automatic reset_during_ack();
    bit         ack;
    logic [7:0] hi_b;
    hi_b = 8'h07;
    seen_q.delete();
    i2c_start();
    write_byte(8'hC2, ack);
    chk("rst_addr_ack", 32'(ack), 32'd1);
    for (int i = 7; i >= 0; i--) write_bit(hi_b[i]);
    host_sda_low = 1'b0; qwait();
    scl = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack_driven", 32'(sda_line), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_sda_released", 32'(sda_line), 32'd1);
    chk("rst_code_zero", 32'(dac_code), 32'd0);
    chk("rst_pd_zero", 32'(pd), 32'd0);
    chk("rst_busy_zero", 32'(busy), 32'd0);
    chk("rst_valid_zero", 32'(valid), 32'd0);
    qwait();
    scl = 1'b0; qwait();
    scl = 1'b1; qwait(); qwait();
    exp_q.delete();
    reset = 1'b1;
    qwait(); qwait();
    chk("rst_idle_after_release", 32'(busy), 32'd0);
    $display("txn reset_during_ack: code=%03h pd=%02b", dac_code, pd);
  endtask

  task automatic main_seq();
    int low0;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_code", 32'(dac_code), 32'd0);
    chk("reset_pd", 32'(pd), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_sda", 32'(sda_line), 32'd1);
    reset = 1'b1;
    qwait();

    run_txn("fast_write", 3, 48'h0000_00C2_07FF, 1'b1, 1);
    chk("lit_7ff_code", 32'(dac_code), 32'h7FF);
    chk("lit_7ff_pd", 32'(pd), 32'd0);

    low0 = dut_low_cnt;
    run_txn("wrong_addr", 3, 48'h0000_00C4_07FF, 1'b1, 0);
    chk("wrong_addr_no_drive", 32'(dut_low_cnt - low0), 32'd0);
    chk("wrong_addr_code_kept", 32'(dac_code), 32'h7FF);

    run_txn("two_pairs", 5, 48'h00C2_2ABC_0123, 1'b1, 2);
    chk("two_pairs_seen", 32'(seen_q.size()), 32'd2);
    if (seen_q.size() == 2) begin
      chk("lit_abc_code", 32'(seen_q[0].code), 32'hABC);
      chk("lit_abc_pd", 32'(seen_q[0].pd), 32'd2);
      chk("lit_123_code", 32'(seen_q[1].code), 32'h123);
      chk("lit_123_pd", 32'(seen_q[1].pd), 32'd0);
    end

    run_txn("half_pair", 2, 48'h0000_0000_C205, 1'b1, 0);
    run_txn("read_req", 1, 48'h0000_0000_00C3, 1'b1, 0);

    low0 = dut_low_cnt;
    run_txn("bad_cmd", 3, 48'h0000_00C2_4000, 1'b1, 0);
    chk("bad_cmd_single_ack", 32'(dut_low_cnt - low0 > 0), 32'd1);
    chk("bad_cmd_code_kept", 32'(dac_code), 32'h123);

    run_txn("abandoned", 2, 48'h0000_0000_C21F, 1'b0, 0);
    run_txn("restart", 3, 48'h0000_00C2_1345, 1'b1, 1);
    chk("lit_345_code", 32'(dac_code), 32'h345);
    chk("lit_345_pd", 32'(pd), 32'd1);

    run_txn("pd_max", 3, 48'h0000_00C2_3A5A, 1'b1, 1);
    chk("lit_a5a_pd", 32'(pd), 32'd3);

    reset_during_ack();

    run_txn("post_reset", 3, 48'h0000_00C2_1567, 1'b1, 1);
    chk("lit_567_code", 32'(dac_code), 32'h567);
    chk("lit_567_pd", 32'(pd), 32'd1);
  endtask

  initial begin
    mark.start    = 1'b0;
    mark.stop     = 1'b0;
    mark.scl_rise = 1'b0;
    mark.scl_fall = 1'b0;
    fork
      monitor();
      main_seq();
    join_any
    disable fork;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
